// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the program ROM and hands
// instructions to decode over valid/ready. Optional FETCH_PERF_CNT_EN adds fetch_cnt.
module fetch_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int PROG_LEN = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rom_oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              bad_jmp
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [31:0]       LEN32    = 32'(PROG_LEN);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [DATA_W-1:0]   instr_nxt;
  logic                valid_nxt, bad_nxt;
  logic                accept, jmp_ok;

  assign accept   = instr_valid & instr_ready;
  // Unsigned compare at full width so targets above PROG_LEN are caught.
  assign jmp_ok   = 32'(jmp_addr) < LEN32;
  assign rom_oe   = (state == FETCH);
  assign rom_addr = pc;
  assign halted   = (state == HALTED);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = instr_valid;
    bad_nxt   = bad_jmp;
    case (state)
      IDLE: if (en) state_nxt = FETCH;
      FETCH: begin
        instr_nxt = rom_data;
        valid_nxt = 1'b1;
        pc_nxt    = (pc == LAST_PC) ? '0 : pc + ADDR_W'(1);
        state_nxt = HOLD;
      end
      HOLD: if (accept) begin
        valid_nxt = 1'b0;
        if (halt) begin
          state_nxt = HALTED;
        end else begin
          if (jmp_req) begin
            if (jmp_ok) pc_nxt = jmp_addr;
            else begin
              pc_nxt  = RST_PC;
              bad_nxt = 1'b1;
            end
          end
          state_nxt = en ? FETCH : IDLE;
        end
      end
      HALTED: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RST_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      bad_jmp     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      bad_jmp     <= bad_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating so long runs never alias back to small counts.
  always_ff @(posedge clk) begin
    if (rst)                              fetch_cnt <= '0;
    else if (accept && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, checked
// against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;
  localparam int ADDR_W = 5, DATA_W = 16, PROG_LEN = 16;

  logic              clk = 0;
  logic              rst, en, instr_ready, jmp_req, halt;
  logic [ADDR_W-1:0] jmp_addr;
  logic              rom_oe, instr_valid, halted, bad_jmp;
  logic [ADDR_W-1:0] rom_addr, pc;
  logic [DATA_W-1:0] rom_data, instr;
  logic [15:0]       cnt_obs;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       fetch_cnt;
  assign cnt_obs = fetch_cnt;
`else
  assign cnt_obs = 16'd0;
`endif

  logic [DATA_W-1:0] rom [0:31];
  assign rom_data = rom_oe ? rom[rom_addr] : '0;

  fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_LEN(PROG_LEN), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .rom_oe(rom_oe), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jmp_req(jmp_req), .jmp_addr(jmp_addr),
    .halt(halt), .pc(pc), .halted(halted), .bad_jmp(bad_jmp)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Model: a pending fetch, at most one unaccepted word, a halt latch.
  bit  m_fetch, m_valid, m_halted, m_bad;
  int  m_pc, m_last;
  logic [DATA_W-1:0] m_instr;
  int  m_cnt;
`ifdef FETCH_PERF_CNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  task automatic model_step();
    if (rst) begin
      m_fetch = 0; m_valid = 0; m_halted = 0; m_bad = 0;
      m_pc = 0; m_instr = '0; m_cnt = 0;
    end else if (m_halted) begin
    end else if (m_fetch) begin
      m_instr = rom[m_pc]; m_valid = 1; m_last = m_pc;
      m_pc = (m_pc + 1) % PROG_LEN; m_fetch = 0;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid = 0;
        if (HAS_CNT && m_cnt < 65535) m_cnt++;
        if (halt) m_halted = 1;
        else begin
          if (jmp_req) begin
            if (int'(jmp_addr) < PROG_LEN) m_pc = int'(jmp_addr);
            else begin m_pc = 0; m_bad = 1; end
          end
          m_fetch = en;
        end
      end
    end else m_fetch = en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!instr_valid && k < 20) begin tick(); k++; end
    n_chk++;
    if (!instr_valid) begin n_fail++; $display("FAIL %s_timeout: instr_valid=%0b want 1", nm, instr_valid); end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; instr_ready = 0; jmp_req = 0; halt = 0; jmp_addr = '0;
    tick(); tick();
    rst = 0;
    n_chk++; if (pc !== 5'd0)        begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_chk++; if (instr_valid !== 0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_chk++; if (instr !== 16'h0)    begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_chk++; if ({halted, bad_jmp, rom_oe} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {halted, bad_jmp, rom_oe}); end
    n_chk++; if (cnt_obs !== 16'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt_obs); end
  endtask

  task automatic test_sequence();
    bit wrapped = 0;
    int prev;
    en = 1; instr_ready = 1;
    tick();
    n_chk++; if (rom_oe !== 1 || rom_addr !== 5'd0) begin n_fail++; $display("FAIL seq_first_fetch: oe=%b addr=%0d want 1/0", rom_oe, rom_addr); end
    n_chk++; if (instr_valid !== 0) begin n_fail++; $display("FAIL seq_latency_early: valid=%b want 0", instr_valid); end
    tick();
    n_chk++; if (instr_valid !== 1 || instr !== 16'hA000) begin n_fail++; $display("FAIL seq_latency: valid=%b instr=%h want 1/a000", instr_valid, instr); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_chk++; if (rom_oe !== 1 || int'(rom_addr) != k) begin n_fail++; $display("FAIL seq_addr: oe=%b addr=%0d want 1/%0d", rom_oe, rom_addr, k); end
      tick();
      n_chk++; if (instr_valid !== 1 || instr !== 16'hA000 + 16'(k)) begin n_fail++; $display("FAIL seq_instr: valid=%b instr=%h want 1/%h", instr_valid, instr, 16'hA000 + 16'(k)); end
    end
    prev = int'(pc);
    for (int c = 0; c < 34; c++) begin
      tick();
      if (prev == PROG_LEN - 1 && pc == 0) wrapped = 1;
      prev = int'(pc);
      n_chk++;
      if (int'(pc) != m_pc || instr_valid !== m_valid || rom_oe !== m_fetch || (m_valid && instr !== m_instr)) begin
        n_fail++; $display("FAIL seq_stream: pc=%0d v=%b oe=%b instr=%h want %0d/%b/%b/%h", pc, instr_valid, rom_oe, instr, m_pc, m_valid, m_fetch, m_instr);
      end
    end
    n_chk++; if (!wrapped || bad_jmp !== 0) begin n_fail++; $display("FAIL seq_wrap: wrapped=%b bad_jmp=%b want 1/0", wrapped, bad_jmp); end
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] pc0;
    instr_ready = 0;
    wait_valid("stall");
    held = instr; pc0 = pc;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++;
      if (instr_valid !== 1 || instr !== held || rom_oe !== 0 || pc !== pc0) begin
        n_fail++; $display("FAIL stall_hold: v=%b instr=%h oe=%b pc=%0d want 1/%h/0/%0d", instr_valid, instr, rom_oe, pc, held, pc0);
      end
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    n_chk++; if (instr_valid !== 0 || rom_oe !== 1 || int'(rom_addr) != m_pc) begin n_fail++; $display("FAIL stall_release: v=%b oe=%b addr=%0d want 0/1/%0d", instr_valid, rom_oe, rom_addr, m_pc); end
  endtask

  task automatic test_jump();
    int k = 0;
    instr_ready = 0;
    while (k < 60) begin
      tick(); k++;
      if (instr_valid) begin
        if (m_last == 3) break;
        instr_ready = 1; tick(); instr_ready = 0;
      end
    end
    n_chk++; if (!(instr_valid && m_last == 3)) begin n_fail++; $display("FAIL jump_find3: valid=%b last=%0d want 1/3", instr_valid, m_last); end
    jmp_req = 1; jmp_addr = 5'd9; instr_ready = 1;
    tick();
    jmp_req = 0; instr_ready = 0;
    n_chk++; if (rom_oe !== 1 || rom_addr !== 5'd9) begin n_fail++; $display("FAIL jump_target: oe=%b addr=%0d want 1/9", rom_oe, rom_addr); end
    tick();
    n_chk++; if (instr_valid !== 1 || instr !== rom[9]) begin n_fail++; $display("FAIL jump_instr: v=%b instr=%h want 1/%h", instr_valid, instr, rom[9]); end
    jmp_req = 1; jmp_addr = 5'd20; instr_ready = 1;
    tick();
    jmp_req = 0; instr_ready = 0;
    n_chk++; if (pc !== 5'd0 || bad_jmp !== 1 || rom_addr !== 5'd0) begin n_fail++; $display("FAIL jump_bad: pc=%0d bad=%b want 0/1", pc, bad_jmp); end
  endtask

  task automatic test_halt();
    logic [ADDR_W-1:0] pc0;
    instr_ready = 0;
    wait_valid("halt");
    pc0 = pc;
    halt = 1; jmp_req = 1; jmp_addr = 5'd5; instr_ready = 1;
    tick();
    halt = 0; jmp_req = 0;
    n_chk++; if (halted !== 1 || rom_oe !== 0 || pc !== pc0 || instr_valid !== 0) begin n_fail++; $display("FAIL halt_enter: h=%b oe=%b pc=%0d v=%b want 1/0/%0d/0", halted, rom_oe, pc, instr_valid, pc0); end
    for (int c = 0; c < 8; c++) tick();
    n_chk++; if (halted !== 1 || rom_oe !== 0 || pc !== pc0) begin n_fail++; $display("FAIL halt_stay: h=%b oe=%b pc=%0d want 1/0/%0d", halted, rom_oe, pc, pc0); end
    rst = 1; tick(); rst = 0;
    n_chk++; if (pc !== 0 || halted !== 0 || bad_jmp !== 0) begin n_fail++; $display("FAIL halt_reset: pc=%0d h=%b bad=%b want 0/0/0", pc, halted, bad_jmp); end
  endtask

  task automatic test_reset_in_hold();
    en = 1; instr_ready = 0;
    wait_valid("rsthold");
    rst = 1; tick(); rst = 0;
    n_chk++; if (instr_valid !== 0 || instr !== 16'h0 || rom_oe !== 0 || cnt_obs !== 16'd0) begin n_fail++; $display("FAIL rst_hold: v=%b instr=%h oe=%b cnt=%0d want 0/0/0/0", instr_valid, instr, rom_oe, cnt_obs); end
    instr_ready = 1;
    for (int a = 1; a <= 3; a++) begin
      wait_valid("cnt");
      tick();
      n_chk++; if (int'(cnt_obs) != m_cnt || (HAS_CNT && int'(cnt_obs) != a)) begin n_fail++; $display("FAIL perf_cnt: got %0d want %0d", cnt_obs, HAS_CNT ? a : 0); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      en          = ($urandom_range(0, 9) != 0);
      instr_ready = $urandom_range(0, 1);
      jmp_req     = ($urandom_range(0, 5) == 0);
      jmp_addr    = ADDR_W'($urandom_range(0, 31));
      halt        = ($urandom_range(0, 79) == 0);
      tick();
      n_chk++;
      if (int'(pc) != m_pc || instr_valid !== m_valid || rom_oe !== m_fetch || halted !== m_halted ||
          bad_jmp !== m_bad || int'(cnt_obs) != m_cnt || (m_valid && instr !== m_instr) || rom_addr !== pc) begin
        n_fail++;
        $display("FAIL random_c%0d: pc=%0d v=%b oe=%b h=%b bad=%b cnt=%0d instr=%h want %0d/%b/%b/%b/%b/%0d/%h",
                 c, pc, instr_valid, rom_oe, halted, bad_jmp, cnt_obs, instr, m_pc, m_valid, m_fetch, m_halted, m_bad, m_cnt, m_instr);
      end
    end
    rst = 0; halt = 0; jmp_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++)  rom[i] = 16'hA000 + 16'(i);
    m_last = 0;
    test_reset();
    test_sequence();
    test_stall();
    test_jump();
    test_halt();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
